// File: rtl/alu_pkg.sv
// Shared opcode, state and flag definitions for the iterative ALU.
// Opcodes 1010/1011 are only meaningful when ITER_ALU_MULH_EN is defined.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_UMUL  = 4'h4,
        OP_SMUL  = 4'h5,
        OP_UDIV  = 4'h6,
        OP_SDIV  = 4'h7,
        OP_UREM  = 4'h8,
        OP_SREM  = 4'h9,
        OP_UMULH = 4'hA,
        OP_SMULH = 4'hB
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } iter_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_div_op(input logic [3:0] code);
        return (code == OP_UDIV) || (code == OP_SDIV) ||
               (code == OP_UREM) || (code == OP_SREM);
    endfunction

endpackage

// File: rtl/iter_divider.sv
// Unsigned radix-2 restoring divider core: one quotient bit per step,
// WIDTH steps after load. Sign handling lives in iter_alu.
module iter_divider #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [CNT_W-1:0] counter,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

    // Partial remainder always stays below the divisor, so the modular
    // W-bit difference is exact whenever the subtraction is taken.
    assign shifted = {remainder, quotient[WIDTH-1]};
    assign fits    = shifted >= {1'b0, divisor_q};
    assign trial   = shifted[WIDTH-1:0] - divisor_q;

    always_ff @(posedge clk) begin
        if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            divisor_q <= divisor;
        end else if (step) begin
            quotient  <= {quotient[WIDTH-2:0], fits};
            remainder <= fits ? trial : shifted[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else if (load) begin
            counter <= '0;
        end else if (step) begin
            counter <= counter + 1'b1;
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU: registered single-cycle ops plus an iterative signed/unsigned
// divider. Define ITER_ALU_MULH_EN to enable UMULH/SMULH (opcodes 1010/1011).
module iter_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             div_by_zero
);

    // Unsigned view of the two's-complement negation: |MIN| = 2^(W-1) fits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    iter_state_t      state;
    logic             accept, div_op, signed_op, sign_a, sign_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [3:0]       op_q;
    logic             sign_a_q, sign_b_q, zero_div_q, ovf_q;
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [WIDTH-1:0] sc_result;
    logic             sc_c, sc_v;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] quo, rem, fix_quo, fix_rem, fix_result;

    assign accept    = (state == IDLE) && start;
    assign div_op    = is_div_op(op);
    assign signed_op = (op == OP_SDIV) || (op == OP_SREM);
    assign sign_a    = signed_op && a[WIDTH-1];
    assign sign_b    = signed_op && b[WIDTH-1];
    assign a_mag     = magnitude(a, sign_a);
    assign b_mag     = magnitude(b, sign_b);
    assign sum_ext   = {1'b0, a} + {1'b0, b};
    assign diff_ext  = {1'b0, a} + {1'b0, ~b} + 1'b1;

`ifdef ITER_ALU_MULH_EN
    logic        [2*WIDTH-1:0] umul_full;
    logic signed [2*WIDTH-1:0] smul_full;
    assign umul_full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign smul_full = $signed(a) * $signed(b);
`endif

    always_comb begin
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        case (op)
            OP_ADD: begin
                sc_result = sum_ext[WIDTH-1:0];
                sc_c      = sum_ext[WIDTH];
                sc_v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff_ext[WIDTH-1:0];
                sc_c      = diff_ext[WIDTH];
                sc_v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:           sc_result = a & b;
            OP_OR:            sc_result = a | b;
            OP_UMUL, OP_SMUL: sc_result = a * b;
`ifdef ITER_ALU_MULH_EN
            OP_UMULH:         sc_result = umul_full[2*WIDTH-1:WIDTH];
            OP_SMULH:         sc_result = smul_full[2*WIDTH-1:WIDTH];
`endif
            default:          sc_result = '0;
        endcase
    end

    // Divide operand capture: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept && div_op) begin
            op_q       <= op;
            sign_a_q   <= sign_a;
            sign_b_q   <= sign_b;
            zero_div_q <= (b == '0);
            ovf_q      <= (op == OP_SDIV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        end
    end

    iter_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && div_op),
        .step      (state == DIV),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .counter   (count),
        .quotient  (quo),
        .remainder (rem)
    );

    // Sign correction stage: quotient sign = sign(a)^sign(b), remainder follows a.
    assign fix_quo    = zero_div_q ? '1 : magnitude(quo, (op_q == OP_SDIV) && (sign_a_q ^ sign_b_q));
    assign fix_rem    = magnitude(rem, (op_q == OP_SREM) && sign_a_q);
    assign fix_result = ((op_q == OP_UREM) || (op_q == OP_SREM)) ? fix_rem : fix_quo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            flags       <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && div_op) begin
                        state <= DIV;
                        busy  <= 1'b1;
                    end else if (accept) begin
                        result      <= sc_result;
                        flags       <= make_flags(sc_result, sc_c, sc_v);
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                DIV: begin
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result      <= fix_result;
                    flags       <= make_flags(fix_result, 1'b0, zero_div_q || ovf_q);
                    div_by_zero <= zero_div_q;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: directed corner cases plus random ops against an
// arithmetic reference model; follows ITER_ALU_MULH_EN like the design.
module tb_iter_alu;

    localparam int W = 32;
    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int n_pass = 0;
    int n_total = 0;

    iter_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .flags       (flags),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: each opcode evaluated with 64-bit integer arithmetic.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [3:0] f,
                                  output logic dz, output int lat);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        longint          t;
        logic            c = 1'b0;
        logic            v = 1'b0;
        r   = '0;
        dz  = 1'b0;
        lat = 1;
        case (o)
            4'h0: begin r = x + y; c = (ux + uy) > 64'hFFFF_FFFF; t = sx + sy; v = (t > MAX_S) || (t < MIN_S); end
            4'h1: begin r = x - y; c = (ux >= uy); t = sx - sy; v = (t > MAX_S) || (t < MIN_S); end
            4'h2: r = x & y;
            4'h3: r = x | y;
            4'h4, 4'h5: r = W'(ux * uy);
            4'h6: begin lat = W + 2; if (y == 0) begin r = '1; dz = 1; v = 1; end else r = x / y; end
            4'h7: begin
                lat = W + 2;
                if (y == 0) begin r = '1; dz = 1; v = 1; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = x; v = 1; end
                else r = W'(sx / sy);
            end
            4'h8: begin lat = W + 2; if (y == 0) begin r = x; dz = 1; v = 1; end else r = x % y; end
            4'h9: begin lat = W + 2; if (y == 0) begin r = x; dz = 1; v = 1; end else r = W'(sx % sy); end
`ifdef ITER_ALU_MULH_EN
            4'hA: r = W'((ux * uy) >> W);
            4'hB: r = W'((sx * sy) >>> W);
`endif
            default: r = '0;
        endcase
        f = {r[W-1], (r == 0), c, v};
    endfunction

    task automatic run(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
        logic [W-1:0] er;
        logic [3:0]   ef;
        logic         edz;
        int           elat;
        int           lat;
        string        tag;
        model(o, x, y, er, ef, edz, elat);
        tag = $sformatf("op%0h %0h,%0h", o, x, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 4'h0; a = $urandom; b = $urandom;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            start = poke && (lat == 5);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, " result"}, 64'(result), 64'(er));
        check({tag, " flags"}, 64'(flags), 64'(ef));
        check({tag, " dbz"}, 64'(div_by_zero), 64'(edz));
        check({tag, " latency"}, 64'(lat), 64'(elat));
        @(posedge clk); #1;
        check({tag, " done_fall"}, 64'(done), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 64'(busy), 0);
        check("rst done", 64'(done), 0);
        check("rst result", 64'(result), 0);
        check("rst flags", 64'(flags), 0);
        check("rst dbz", 64'(div_by_zero), 0);
        @(negedge clk); reset = 1'b0;

        run(4'h1, 32'd5, 32'd7, 0);
        run(4'h0, 32'h7FFF_FFFF, 32'd1, 0);

        // Abort a UDIV eight edges in with an asynchronous reset.
        @(negedge clk);
        start = 1'b1; op = 4'h6; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort busy", 64'(busy), 0);
        check("abort done", 64'(done), 0);
        check("abort result", 64'(result), 0);
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        check("abort no done", 64'(seen), 0);
        run(4'h0, 32'd3, 32'd4, 0);

        run(4'h6, 32'd100, 32'd7, 1);
        run(4'h8, 32'd100, 32'd7, 0);
        run(4'h7, -32'sd7, 32'd2, 0);
        run(4'h9, -32'sd7, 32'd2, 1);
        run(4'h7, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run(4'h6, 32'd9, 32'd0, 0);
        run(4'h8, 32'd9, 32'd0, 0);
        run(4'h9, -32'sd9, 32'd0, 0);
        run(4'h2, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
        run(4'h3, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
        run(4'h5, 32'hFFFF_FFFD, 32'd7, 0);
        run(4'hB, 32'hFFFF_FFFF, 32'd2, 0);
        run(4'hA, 32'hFFFF_FFFF, 32'd2, 0);
        run(4'hC, 32'd1, 32'd2, 0);
        run(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] ro;
            ro = 4'($urandom_range(0, 15));
            run(ro, pick(), pick(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
